// File: rtl/fpu_ctrl_if.sv
// Request/response channel between an issuing pipeline and the fpu_ctrl sequencer.
interface fpu_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_fops;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_illegal;

  modport master (
    output in_valid, in_fops, in_rs1, in_rs2, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_fops, in_rs1, in_rs2, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_illegal
  );
endinterface

// File: rtl/fpu_ctrl.sv
// Single-issue FP sequencer: captures one request, waits the per-op latency, holds the result.
// falu: combinational single-precision unit; subnormals flush to zero, Inf/NaN arithmetic gives qNaN.
module falu (
  input  logic [3:0]  fops,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [31:0] res
);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // value = m * 2^x, normalised to 24 bits + guard/sticky, round to nearest-even
  function automatic logic [31:0] pack(input logic s, input int x, input logic [63:0] m);
    int unsigned p;
    int          e;
    logic [26:0] m27;
    logic [24:0] r;
    logic        sticky;
    p = 0;
    for (int unsigned i = 0; i < 64; i++) if (m[i]) p = i;
    if (p >= 26) begin
      m27    = 27'(m >> (p - 26));
      sticky = |(m & ((64'd1 << (p - 26)) - 64'd1));
    end else begin
      m27    = 27'(m << (26 - p));
      sticky = 1'b0;
    end
    e = x + int'(p) + 127;
    r = {1'b0, m27[26:3]} + 25'(m27[2] & (m27[1] | m27[0] | sticky | m27[3]));
    if (r[24]) begin
      r = r >> 1;
      e = e + 1;
    end
    if (m == 64'd0 || e <= 0) return {s, 31'd0};
    if (e >= 255) return {s, 8'hFF, 23'd0};
    return {s, 8'(e), r[22:0]};
  endfunction

  function automatic logic is_nan(input logic [31:0] a);
    return (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] big, sml;
    logic [26:0] mbig, msml, mfull;
    logic [27:0] sum;
    int unsigned d;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return QNAN;
    if (a[30:0] >= b[30:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    if (big[30:23] == 8'd0) return {a[31] & b[31], 31'd0};
    mbig  = {1'b1, big[22:0], 3'b000};
    mfull = (sml[30:23] == 8'd0) ? '0 : {1'b1, sml[22:0], 3'b000};
    d     = 32'(big[30:23]) - 32'(sml[30:23]);
    if (d > 26) msml = {26'd0, |mfull};
    else        msml = (mfull >> d) | 27'(|(mfull & ((27'd1 << d) - 27'd1)));
    if (big[31] == sml[31]) sum = {1'b0, mbig} + {1'b0, msml};
    else                    sum = {1'b0, mbig} - {1'b0, msml};
    if (sum == '0) return {a[31] & b[31], 31'd0};
    return pack(big[31], int'(big[30:23]) - 153, 64'(sum));
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return QNAN;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    return pack(s, int'(a[30:23]) + int'(b[30:23]) - 300,
                64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]}));
  endfunction

  function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [63:0] num, den, q, rm;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return QNAN;
    if (b[30:23] == 8'd0) return (a[30:23] == 8'd0) ? QNAN : {s, 8'hFF, 23'd0};
    if (a[30:23] == 8'd0) return {s, 31'd0};
    num = 64'({1'b1, a[22:0]}) << 26;
    den = 64'({1'b1, b[22:0]});
    q   = num / den;
    rm  = num % den;
    return pack(s, int'(a[30:23]) - int'(b[30:23]) - 27, (q << 1) | 64'(rm != 64'd0));
  endfunction

  function automatic logic [31:0] fsqrt(input logic [31:0] a);
    logic [63:0] m, r, t;
    int          ex;
    if (a[30:23] == 8'd0) return {a[31], 31'd0};
    if (a[31] || a[30:23] == 8'hFF) return QNAN;
    ex = int'(a[30:23]) - 150;
    m  = 64'({1'b1, a[22:0]});
    // even exponent so it halves exactly; 28 extra bits give a 26+ bit root
    if (ex % 2 != 0) begin
      m  = m << 1;
      ex = ex - 1;
    end
    m = m << 28;
    r = '0;
    for (int unsigned i = 0; i < 28; i++) begin
      t = r | (64'd1 << (27 - i));
      if (t * t <= m) r = t;
    end
    return pack(1'b0, (ex - 28) / 2 - 1, (r << 1) | 64'(r * r != m));
  endfunction

  logic [31:0] ka, kb, nan_pick;
  logic        unord, eq, lt;

  always_comb begin
    ka       = rs1[31] ? ~rs1 : (rs1 | 32'h8000_0000);
    kb       = rs2[31] ? ~rs2 : (rs2 | 32'h8000_0000);
    unord    = is_nan(rs1) | is_nan(rs2);
    eq       = (rs1 == rs2) || (rs1[30:0] == 31'd0 && rs2[30:0] == 31'd0);
    lt       = !eq && (ka < kb);
    nan_pick = is_nan(rs1) ? (is_nan(rs2) ? QNAN : rs2) : rs1;
    res      = '0;
    case (fops)
      4'h0:    res = fadd(rs1, rs2);
      4'h1:    res = fadd(rs1, {~rs2[31], rs2[30:0]});
      4'h2:    res = fmul(rs1, rs2);
      4'h3:    res = fdiv(rs1, rs2);
      4'h4:    res = fsqrt(rs1);
      4'h5:    res = {rs2[31], rs1[30:0]};
      4'h6:    res = {~rs2[31], rs1[30:0]};
      4'h7:    res = {rs1[31] ^ rs2[31], rs1[30:0]};
      4'h8:    res = unord ? nan_pick : (lt ? rs1 : rs2);
      4'h9:    res = unord ? nan_pick : (lt ? rs2 : rs1);
      4'hA:    res = {31'd0, !unord && eq};
      4'hB:    res = {31'd0, !unord && lt};
      4'hC:    res = {31'd0, !unord && (lt || eq)};
      default: res = '0;
    endcase
  end
endmodule

module fpu_ctrl #(
  parameter int unsigned LAT_ADD  = 2,
  parameter int unsigned LAT_MUL  = 3,
  parameter int unsigned LAT_DIV  = 12,
  parameter int unsigned LAT_SQRT = 16,
  parameter int unsigned LAT_MISC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  output logic       busy,
  fpu_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [3:0]  op_fops;
  logic [31:0] op_rs1, op_rs2;
  logic [4:0]  op_tag;
  logic        op_illegal;
  logic [31:0] alu_res;
  logic        accept;

  function automatic logic [4:0] lat_m1(input logic [3:0] fops);
    case (fops)
      4'h0, 4'h1: return 5'(LAT_ADD - 1);
      4'h2:       return 5'(LAT_MUL - 1);
      4'h3:       return 5'(LAT_DIV - 1);
      4'h4:       return 5'(LAT_SQRT - 1);
      4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC: return 5'(LAT_MISC - 1);
      default:    return 5'd0;
    endcase
  endfunction

  falu u_falu (.fops(op_fops), .rs1(op_rs1), .rs2(op_rs2), .res(alu_res));

  assign accept = bus.in_valid & bus.in_ready & ~flush;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) state <= IDLE;
    else                 state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    if (cnt == 5'd0) state_nx = DONE;
      DONE:    if (bus.out_valid && bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    busy          = (state != IDLE);
  end

  // Operand registers only load on accept, so falu inputs are frozen through EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt             <= '0;
      op_fops         <= '0;
      op_rs1          <= '0;
      op_rs2          <= '0;
      op_tag          <= '0;
      op_illegal      <= 1'b0;
      bus.out_data    <= '0;
      bus.out_tag     <= '0;
      bus.out_illegal <= 1'b0;
    end else begin
      if (accept) begin
        op_fops    <= bus.in_fops;
        op_rs1     <= bus.in_rs1;
        op_rs2     <= bus.in_rs2;
        op_tag     <= bus.in_tag;
        op_illegal <= (bus.in_fops >= 4'hD);
        cnt        <= lat_m1(bus.in_fops);
      end else if (state == EXEC && cnt != 5'd0) begin
        cnt <= cnt - 5'd1;
      end
      if (state == EXEC && cnt == 5'd0 && !flush) begin
        bus.out_data    <= op_illegal ? '0 : alu_res;
        bus.out_tag     <= op_tag;
        bus.out_illegal <= op_illegal;
      end
    end
  end
endmodule

// File: tb/tb_fpu_ctrl.sv
// Directed and randomized checks of fpu_ctrl against an integer-valued float reference model.
module tb_fpu_ctrl;
  localparam int unsigned LA = 2, LM = 3, LD = 12, LS = 16, LX = 1;

  logic clk = 1'b0;
  logic rst_n, flush, busy;
  int   tests = 0;
  int   fails = 0;

  fpu_ctrl_if bus();

  fpu_ctrl #(.LAT_ADD(LA), .LAT_MUL(LM), .LAT_DIV(LD), .LAT_SQRT(LS), .LAT_MISC(LX)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // exact integer (|v| < 2^24) to single-precision bits
  function automatic logic [31:0] f(input int v);
    int unsigned m;
    int unsigned p;
    if (v == 0) return 32'd0;
    m = (v < 0) ? 32'(-v) : 32'(v);
    p = 0;
    for (int unsigned i = 0; i < 32; i++) if (m[i]) p = i;
    return {v < 0, 8'(127 + p), 23'(m << (23 - p))};
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int rnd_nz();
    int v;
    v = int'($urandom_range(1, 20));
    return ($urandom_range(0, 1) == 1) ? -v : v;
  endfunction

  function automatic int unsigned lat_of(input logic [3:0] op);
    if (op <= 4'h1) return LA;
    if (op == 4'h2) return LM;
    if (op == 4'h3) return LD;
    if (op == 4'h4) return LS;
    if (op <= 4'hC) return LX;
    return 1;
  endfunction

  task automatic gen(input logic [3:0] op, output logic [31:0] r1, output logic [31:0] r2,
                     output logic [31:0] ex);
    int a, b;
    a = rnd_nz();
    b = rnd_nz();
    if (op >= 4'hA && op <= 4'hC && $urandom_range(0, 2) == 0) b = a;
    r1 = f(a);
    r2 = f(b);
    case (op)
      4'h0: ex = f(a + b);
      4'h1: ex = f(a - b);
      4'h2: ex = f(a * b);
      4'h3: begin r1 = f(a * b); ex = f(a); end
      4'h4: begin
        a  = int'($urandom_range(1, 300));
        r1 = f(a * a);
        r2 = $urandom;
        ex = f(a);
      end
      4'h5: ex = f((b < 0) ? -iabs(a) : iabs(a));
      4'h6: ex = f((b < 0) ? iabs(a) : -iabs(a));
      4'h7: ex = f(((a < 0) != (b < 0)) ? -iabs(a) : iabs(a));
      4'h8: ex = f((a < b) ? a : b);
      4'h9: ex = f((a > b) ? a : b);
      4'hA: ex = 32'(a == b);
      4'hB: ex = 32'(a < b);
      4'hC: ex = 32'(a <= b);
      default: begin r1 = $urandom; r2 = $urandom; ex = 32'd0; end
    endcase
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    int n = 0;
    while (!bus.in_ready && n < 64) begin
      step();
      n++;
    end
    check("in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_fops  = op;
    bus.in_rs1   = a;
    bus.in_rs2   = b;
    bus.in_tag   = tag;
    step();
    bus.in_valid = 1'b0;
    // scramble request lines after accept; the captured operands must win
    bus.in_fops  = ~op;
    bus.in_rs1   = ~a;
    bus.in_rs2   = ~b;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!bus.out_valid && n < 64) begin
      step();
      n++;
    end
  endtask

  initial begin
    int          n;
    logic        ov;
    logic [3:0]  op;
    logic [4:0]  tg;
    int          bp;
    logic [31:0] r1, r2, ex;

    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_fops = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_tag = '0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_out_tag", 32'(bus.out_tag), 32'd0);
    check("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // add 1.0 + 2.0
    bus.out_ready = 1'b1;
    issue(4'h0, 32'h3F80_0000, 32'h4000_0000, 5'd3);
    wait_result(n);
    check("add_lat", 32'(n), 32'(LA));
    check("add_data", bus.out_data, 32'h4040_0000);
    check("add_tag", 32'(bus.out_tag), 32'd3);
    check("add_illegal", 32'(bus.out_illegal), 32'd0);
    step();
    check("add_idle", 32'(bus.in_ready), 32'd1);

    // div 6.0 / 2.0 under back-pressure
    bus.out_ready = 1'b0;
    issue(4'h3, 32'h40C0_0000, 32'h4000_0000, 5'd4);
    wait_result(n);
    check("div_lat", 32'(n), 32'(LD));
    check("div_data", bus.out_data, 32'h4040_0000);
    for (int i = 0; i < 5; i++) begin
      step();
      check("div_hold_valid", 32'(bus.out_valid), 32'd1);
      check("div_hold_data", bus.out_data, 32'h4040_0000);
    end
    bus.out_ready = 1'b1;
    step();
    check("div_release_ready", 32'(bus.in_ready), 32'd1);
    check("div_release_valid", 32'(bus.out_valid), 32'd0);

    // sign-inject with a second request held pending while busy
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_fops = 4'h5;
    bus.in_rs1 = 32'h3F80_0000; bus.in_rs2 = 32'h8000_0000; bus.in_tag = 5'd5;
    step();
    bus.in_fops = 4'h0; bus.in_rs1 = 32'h3F80_0000; bus.in_rs2 = 32'h4000_0000; bus.in_tag = 5'd9;
    step();
    check("sgnj_valid", 32'(bus.out_valid), 32'd1);
    check("sgnj_data", bus.out_data, 32'hBF80_0000);
    check("sgnj_tag", 32'(bus.out_tag), 32'd5);
    check("sgnj_in_ready", 32'(bus.in_ready), 32'd0);
    check("sgnj_busy", 32'(busy), 32'd1);
    step();
    check("sgnj_hold_tag", 32'(bus.out_tag), 32'd5);
    bus.out_ready = 1'b1;
    step();
    check("sgnj_no_same_cycle_accept", 32'(busy), 32'd0);
    step();
    check("second_accepted", 32'(busy), 32'd1);
    bus.in_valid = 1'b0;
    wait_result(n);
    check("second_lat", 32'(n), 32'(LA));
    check("second_data", bus.out_data, 32'h4040_0000);
    check("second_tag", 32'(bus.out_tag), 32'd9);
    step();

    // flush mid-mul, then flush blocking an accept, then a clean mul
    issue(4'h2, 32'h4000_0000, 32'h4040_0000, 5'd6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    ov = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ov |= bus.out_valid;
      step();
    end
    check("flush_no_result", 32'(ov), 32'd0);
    bus.in_valid = 1'b1; bus.in_fops = 4'h0; flush = 1'b1;
    step();
    bus.in_valid = 1'b0; flush = 1'b0;
    check("flush_blocks_accept", 32'(busy), 32'd0);
    issue(4'h2, 32'h4000_0000, 32'h4040_0000, 5'd6);
    wait_result(n);
    check("mul_lat", 32'(n), 32'(LM));
    check("mul_data", bus.out_data, 32'h40C0_0000);
    step();

    // illegal op
    issue(4'hE, 32'h3F80_0000, 32'h3F80_0000, 5'd7);
    wait_result(n);
    check("ill_lat", 32'(n), 32'd1);
    check("ill_flag", 32'(bus.out_illegal), 32'd1);
    check("ill_data", bus.out_data, 32'd0);
    check("ill_tag", 32'(bus.out_tag), 32'd7);
    step();

    // sqrt dropped by reset at accept+5, then completed normally
    issue(4'h4, 32'h4180_0000, 32'd0, 5'd12);
    repeat (4) step();
    check("sqrt_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step();
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_data", bus.out_data, 32'd0);
    check("mid_rst_tag", 32'(bus.out_tag), 32'd0);
    check("mid_rst_illegal", 32'(bus.out_illegal), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    ov = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      ov |= bus.out_valid;
    end
    check("mid_rst_no_result", 32'(ov), 32'd0);
    issue(4'h4, 32'h4180_0000, 32'd0, 5'd12);
    wait_result(n);
    check("sqrt_lat", 32'(n), 32'(LS));
    check("sqrt_data", bus.out_data, 32'h4080_0000);
    step();

    // randomized operations with random back-pressure
    for (int k = 0; k < 40; k++) begin
      op = 4'($urandom_range(0, 15));
      tg = 5'($urandom);
      bp = int'($urandom_range(0, 3));
      gen(op, r1, r2, ex);
      bus.out_ready = (bp == 0);
      issue(op, r1, r2, tg);
      wait_result(n);
      check("rnd_lat", 32'(n), 32'(lat_of(op)));
      check("rnd_data", bus.out_data, ex);
      check("rnd_tag", 32'(bus.out_tag), 32'(tg));
      check("rnd_illegal", 32'(bus.out_illegal), 32'(op >= 4'hD));
      for (int j = 0; j < bp; j++) begin
        step();
        check("rnd_hold_valid", 32'(bus.out_valid), 32'd1);
        check("rnd_hold_data", bus.out_data, ex);
      end
      bus.out_ready = 1'b1;
      step();
      check("rnd_release", 32'(bus.out_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fpu_ctrl.md
FPU_CTRL -- requirements
Module: fpu_ctrl

Interface
REQ-001 Parameter LAT_ADD, default 2: cycles from accept to result for fops 0x0/0x1 (add/sub).
REQ-002 Parameter LAT_MUL, default 3: latency for fops 0x2 (mul).
REQ-003 Parameter LAT_DIV, default 12: latency for fops 0x3 (div).
REQ-004 Parameter LAT_SQRT, default 16: latency for fops 0x4 (sqrt).
REQ-005 Parameter LAT_MISC, default 1: latency for fops 0x5-0xC (sign-inject, min/max, compare).
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 in_valid  input  1  request present.
REQ-009 in_ready  output  1  controller can accept a request.
REQ-010 in_fops  input  4  operation code, same encoding as the falu fops field.
REQ-011 in_rs1  input  32  operand 1, IEEE-754 single.
REQ-012 in_rs2  input  32  operand 2, IEEE-754 single.
REQ-013 in_tag  input  5  destination register tag, returned unchanged.
REQ-014 flush  input  1  abort any in-flight operation.
REQ-015 out_valid  output  1  result available.
REQ-016 out_ready  input  1  consumer accepts result.
REQ-017 out_data  output  32  result word.
REQ-018 out_tag  output  5  tag of the completed request.
REQ-019 out_illegal  output  1  completed request had an unsupported fops (0xD-0xF).
REQ-020 busy  output  1  high in any state other than IDLE.

Function
REQ-021 The block SHALL instantiate one falu and drive its fops/rs1/rs2 only from internal operand registers captured at accept; falu inputs SHALL NOT change while in EXEC.
REQ-022 States SHALL be IDLE, EXEC, DONE; in_ready SHALL equal (state==IDLE) and SHALL NOT depend combinationally on in_valid.
REQ-023 Accept occurs on an edge with in_valid & in_ready & !flush: operands, fops and tag are registered, a down-counter is loaded with (latency-1) for that fops, and the state moves to EXEC.
REQ-024 In EXEC the counter SHALL decrement each cycle; on the edge where it equals 0 the falu output SHALL be captured into out_data and the state moves to DONE, so out_valid rises exactly LAT cycles after the accepting edge.
REQ-025 fops 0xD-0xF SHALL use latency 1, set out_illegal=1 and out_data=0x00000000.
REQ-026 In DONE, out_valid=1 and out_data/out_tag/out_illegal SHALL hold stable until out_valid & out_ready, then return to IDLE; no new request is accepted in that same cycle.
REQ-027 flush SHALL force IDLE on the next edge from any state, discard the in-flight result, deassert out_valid, and block an accept in the same cycle.
REQ-028 The counter SHALL be 5 bits wide; latency parameters SHALL be in range 1..32, and a value of 1 SHALL load 0 and complete after one EXEC cycle.
REQ-029 in_fops/in_rs1/in_rs2 changes outside an accept edge SHALL have no effect on out_data.

Reset
REQ-030 With rst_n low at an edge: state=IDLE, counter=0, out_valid=0, out_data=0, out_tag=0, out_illegal=0, busy=0; in_ready=1 from the first edge after rst_n rises.
REQ-031 Reset asserted mid-EXEC or in DONE SHALL drop the operation with no result produced.

Verification
REQ-032 Add: fops=0x0, rs1=0x3F800000, rs2=0x40000000, tag=3, out_ready=1 -> out_valid exactly 2 cycles after accept, out_data=0x40400000, out_tag=3, out_illegal=0.
REQ-033 Div with back-pressure: fops=0x3, rs1=0x40C00000, rs2=0x40000000, out_ready=0 -> out_valid at accept+12, out_data=0x40400000 held for 5 cycles until out_ready=1, then in_ready=1 on the next cycle.
REQ-034 Sign-inject: fops=0x5, rs1=0x3F800000, rs2=0x80000000 -> out_data=0xBF800000 at accept+1; in_valid held high with a second request -> not accepted while busy=1.
REQ-035 Flush: mul fops=0x2, rs1=0x40000000, rs2=0x40400000, flush pulsed at accept+1 -> out_valid never rises, IDLE next cycle; a rerun without flush -> 0x40C00000 at accept+3.
REQ-036 Illegal/reset: fops=0xE -> out_illegal=1, out_data=0 at accept+1; sqrt fops=0x4, rs1=0x41800000 with rst_n low at accept+5 -> no out_valid, all outputs at reset values.
